// File: rtl/pe_cfg_pkg.sv
// pe_cfg_pkg: shared state encoding and sizing helpers
// for the PE configuration chain loader.
package pe_cfg_pkg;

   localparam int CFG_WORD_W = 32;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_SHIFT  = 3'd2,
      S_VERIFY = 3'd3,
      S_FINISH = 3'd4
   } cfg_state_e;

   function automatic int cfg_cnt_w(input int chain_len);
      return $clog2(chain_len + 1);
   endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// cfg_word_serializer: one-word buffer that turns stream words
// into single bits, LSB first, with same-cycle bypass and refill.
module cfg_word_serializer
   import pe_cfg_pkg::*;
#(
   parameter int WORD_W = CFG_WORD_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              en,
   input  logic              final_bit,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              bit_valid,
   output logic              bit_data,
   input  logic              bit_take
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

   logic [WORD_W-1:0] word_q;
   logic [IDX_W-1:0]  idx_q;
   logic              full_q;
   logic              last;

   assign last      = full_q && (idx_q == IDX_LAST);
   // an empty buffer must still accept the word holding the final bit
   assign s_ready   = en && (!full_q || (last && !final_bit));
   assign bit_valid = en && (full_q || s_valid);
   assign bit_data  = full_q ? word_q[idx_q] : s_data[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_q <= '0;
         idx_q  <= '0;
         full_q <= 1'b0;
      end else if (flush) begin
         idx_q  <= '0;
         full_q <= 1'b0;
      end else if (bit_take) begin
         if (full_q && !last) begin
            idx_q <= idx_q + IDX_W'(1);
         end else if (s_ready && s_valid) begin
            word_q <= s_data;
            if (full_q) begin
               idx_q <= '0;
            end else begin
               idx_q  <= IDX_W'(1);
               full_q <= (WORD_W > 1);
            end
         end else begin
            full_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pe_config_loader.sv
// pe_config_loader: clears and serially loads one PE config chain.
// Build option CFG_READBACK_EN adds a circulate-and-compare pass.
module pe_config_loader
   import pe_cfg_pkg::*;
#(
   parameter int WORD_W    = CFG_WORD_W,
   parameter int CHAIN_LEN = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              cfg_reset,
   output logic              cfg_shift,
   output logic              cfg_data,
   input  logic              cfg_tail,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CFG_CNT_W = cfg_cnt_w(CHAIN_LEN);
   localparam logic [CFG_CNT_W-1:0] CNT_LAST = CFG_CNT_W'(CHAIN_LEN - 1);
   localparam logic [CFG_CNT_W-1:0] CNT_FULL = CFG_CNT_W'(CHAIN_LEN);

   cfg_state_e           state_q;
   cfg_state_e           state_d;
   logic [CFG_CNT_W-1:0] cnt_q;
   logic                 cfg_reset_q;
   logic                 cfg_shift_q;
   logic                 data_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 en;
   logic                 final_bit;
   logic                 bit_valid;
   logic                 bit_data;
   logic                 take;

   assign en        = (state_q == S_SHIFT) && (cnt_q != CNT_FULL);
   assign final_bit = (cnt_q == CNT_LAST);
   assign take      = bit_valid;

   cfg_word_serializer #(
      .WORD_W(WORD_W)
   ) u_ser (
      .clk      (clk),
      .reset    (reset),
      .flush    (state_q == S_CLEAR),
      .en       (en),
      .final_bit(final_bit),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .bit_valid(bit_valid),
      .bit_data (bit_data),
      .bit_take (take)
   );

   // SHIFT lingers one cycle after the last take so the final
   // registered shift pulse reaches the chain before moving on.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start) state_d = S_CLEAR;
         S_CLEAR:  state_d = S_SHIFT;
         S_SHIFT: begin
            if (cnt_q == CNT_FULL) begin
`ifdef CFG_READBACK_EN
               state_d = S_VERIFY;
`else
               state_d = S_FINISH;
`endif
            end
         end
         S_VERIFY: if (cnt_q == CNT_LAST) state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         cfg_reset_q <= 1'b0;
         cfg_shift_q <= 1'b0;
         data_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_reset_q <= (state_d == S_CLEAR);
         cfg_shift_q <= take || (state_d == S_VERIFY);
         data_q      <= take && bit_data;
         busy_q      <= (state_d != S_IDLE);
         done_q      <= (state_d == S_FINISH);
         if (state_q == S_CLEAR) begin
            cnt_q <= '0;
         end else if (take) begin
            cnt_q <= cnt_q + CFG_CNT_W'(1);
         end else if (state_q == S_SHIFT && state_d != S_SHIFT) begin
            cnt_q <= '0;
         end else if (state_q == S_VERIFY) begin
            cnt_q <= cnt_q + CFG_CNT_W'(1);
         end
      end
   end

`ifdef CFG_READBACK_EN
   logic [CHAIN_LEN-1:0] shadow_q;
   logic [CHAIN_LEN:0]   shadow_ext;
   logic                 err_q;

   // shadow rotates alongside the chain so bit 0 is always the
   // value expected at the tail this cycle
   always_comb begin
      shadow_ext = {bit_data, shadow_q};
      if (state_q == S_VERIFY) shadow_ext = {shadow_q[0], shadow_q};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (take || state_q == S_VERIFY) begin
            shadow_q <= shadow_ext[CHAIN_LEN:1];
         end
         if (state_q == S_IDLE && start) begin
            err_q <= 1'b0;
         end else if (state_q == S_VERIFY && cfg_tail != shadow_q[0]) begin
            err_q <= 1'b1;
         end
      end
   end

   assign cfg_data = (state_q == S_VERIFY) ? cfg_tail : data_q;
   assign err      = err_q;
`else
   logic unused_tail;
   assign unused_tail = cfg_tail;
   assign cfg_data    = data_q;
   assign err         = 1'b0;
`endif

   assign cfg_reset = cfg_reset_q;
   assign cfg_shift = cfg_shift_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_pe_config_loader.sv
// tb_pe_config_loader: directed checks of the config chain loader
// using behavioural chain models on two differently sized instances.
module tb_pe_config_loader;

   localparam int WW = 32;
   localparam int NA = 14;
   localparam int NB = 40;
`ifdef CFG_READBACK_EN
   localparam int VA = NA;
   localparam int VB = NB;
`else
   localparam int VA = 0;
   localparam int VB = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          a_start = 0, a_valid = 0, a_flip = 0, a_clr = 0;
   logic [WW-1:0] a_data = '0;
   logic          a_ready, a_creset, a_shift, a_cdata, a_tail;
   logic          a_busy, a_done, a_err;
   logic [NA-1:0] a_chain = '0;

   logic          b_start = 0, b_valid = 0, b_clr = 0;
   logic [WW-1:0] b_data = '0;
   logic          b_ready, b_creset, b_shift, b_cdata, b_tail;
   logic          b_busy, b_done, b_err;
   logic [NB-1:0] b_chain = '0;

   pe_config_loader #(.WORD_W(WW), .CHAIN_LEN(NA)) u_a (
      .clk(clk), .reset(reset), .start(a_start),
      .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
      .cfg_reset(a_creset), .cfg_shift(a_shift),
      .cfg_data(a_cdata), .cfg_tail(a_tail),
      .busy(a_busy), .done(a_done), .err(a_err)
   );

   pe_config_loader #(.WORD_W(WW), .CHAIN_LEN(NB)) u_b (
      .clk(clk), .reset(reset), .start(b_start),
      .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
      .cfg_reset(b_creset), .cfg_shift(b_shift),
      .cfg_data(b_cdata), .cfg_tail(b_tail),
      .busy(b_busy), .done(b_done), .err(b_err)
   );

   // chain models: shift in at the top, tail is bit 0
   assign a_tail = a_chain[0] ^ a_flip;
   assign b_tail = b_chain[0];
   always @(posedge clk) begin
      if (a_creset) a_chain <= '0;
      else if (a_shift) a_chain <= {a_cdata, a_chain[NA-1:1]};
      if (b_creset) b_chain <= '0;
      else if (b_shift) b_chain <= {b_cdata, b_chain[NB-1:1]};
   end

   int a_t0, a_rn, a_rat, a_acc, a_aat, a_sh, a_first, a_last, a_dn, a_dat;
   always @(posedge clk) begin
      if (a_clr) begin
         a_rn <= 0; a_acc <= 0; a_sh <= 0; a_dn <= 0;
         a_rat <= -1; a_aat <= -1; a_dat <= -1;
      end else begin
         if (a_start && !a_busy && reset) a_t0 <= cyc;
         if (a_creset) begin a_rn <= a_rn + 1; a_rat <= cyc - a_t0; end
         if (a_valid && a_ready) begin
            a_acc <= a_acc + 1; a_aat <= cyc - a_t0;
         end
         if (a_shift) begin
            if (a_sh == 0) a_first <= cyc;
            a_last <= cyc; a_sh <= a_sh + 1;
         end
         if (a_done) begin a_dn <= a_dn + 1; a_dat <= cyc - a_t0; end
      end
   end

   int b_t0, b_acc, b_sh, b_first, b_last, b_dn, b_dat;
   always @(posedge clk) begin
      if (b_clr) begin
         b_acc <= 0; b_sh <= 0; b_dn <= 0; b_dat <= -1;
      end else begin
         if (b_start && !b_busy && reset) b_t0 <= cyc;
         if (b_valid && b_ready) b_acc <= b_acc + 1;
         if (b_shift) begin
            if (b_sh == 0) b_first <= cyc;
            b_last <= cyc; b_sh <= b_sh + 1;
         end
         if (b_done) begin b_dn <= b_dn + 1; b_dat <= cyc - b_t0; end
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr_mon();
      @(negedge clk); a_clr = 1; b_clr = 1;
      @(negedge clk); a_clr = 0; b_clr = 0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_outs_a", {a_ready, a_creset, a_shift, a_cdata,
                           a_busy, a_done, a_err}, 0);
      check("rst_outs_b", {b_ready, b_creset, b_shift, b_cdata,
                           b_busy, b_done, b_err}, 0);
      reset = 1;
      clr_mon();

      // basic load with a spurious start while shifting
      a_start = 1; a_data = 32'h0000_2A5B; a_valid = 1;
      @(negedge clk); a_start = 0;
      repeat (4) @(negedge clk);
      a_start = 1;
      @(negedge clk); a_start = 0;
      repeat (45) @(negedge clk);
      a_valid = 0;
      check("a_rst_pulses", a_rn, 1);
      check("a_rst_cycle", a_rat, 1);
      check("a_words", a_acc, 1);
      check("a_word_cycle", a_aat, 2);
      check("a_shifts", a_sh, NA + VA);
      check("a_bubbles", a_last - a_first + 1 - a_sh, 0);
      check("a_dones", a_dn, 1);
      check("a_done_cycle", a_dat, 17 + VA);
      check("a_chain", a_chain, 14'h2A5B);
      check("a_idle", {a_busy, a_ready}, 0);
      check("a_err", a_err, 0);

      // multi-word with a 3-cycle stall, extra words refused
      clr_mon();
      b_start = 1; b_data = 32'hFFFF_FFFF; b_valid = 1;
      @(negedge clk); b_start = 0;
      @(negedge clk);
      @(negedge clk); b_valid = 0;
      repeat (34) @(negedge clk);
      b_valid = 1; b_data = 32'h0000_00A5;
      @(negedge clk); b_data = 32'hDEAD_BEEF;
      repeat (60) @(negedge clk);
      b_valid = 0;
      check("b_words", b_acc, 2);
      check("b_shifts", b_sh, NB + VB);
      check("b_bubbles", b_last - b_first + 1 - b_sh, 3);
      check("b_dones", b_dn, 1);
      check("b_done_cycle", b_dat, 46 + VB);
      check("b_chain", b_chain, 40'hA5_FFFF_FFFF);

`ifdef CFG_READBACK_EN
      // verify pass
      clr_mon();
      a_start = 1; a_data = 32'h0000_1234; a_valid = 1;
      @(negedge clk); a_start = 0;
      repeat (40) @(negedge clk);
      check("v_chain", a_chain, 14'h1234);
      check("v_err", a_err, 0);
      check("v_done_cycle", a_dat, 31);

      // verify fail: corrupt the tail on verify cycle 5
      clr_mon();
      a_start = 1;
      @(negedge clk); a_start = 0;
      repeat (21) @(negedge clk);
      a_flip = 1;
      @(negedge clk); a_flip = 0;
      repeat (20) @(negedge clk);
      check("vf_dones", a_dn, 1);
      check("vf_err", a_err, 1);
      repeat (5) @(negedge clk);
      check("vf_err_held", a_err, 1);
      a_start = 1;
      @(negedge clk); a_start = 0;
      check("vf_err_clr", a_err, 0);
      repeat (40) @(negedge clk);
      check("vf_reload_err", a_err, 0);
`endif

      // abort at shift 7
      clr_mon();
      a_start = 1; a_data = 32'h0000_3FFF; a_valid = 1;
      @(negedge clk); a_start = 0;
      for (int i = 0; i < 40 && a_sh < 7; i++) @(negedge clk);
      check("ab_reach7", a_sh, 7);
      reset = 0;
      #1;
      check("ab_outs", {a_ready, a_creset, a_shift, a_cdata,
                        a_busy, a_done, a_err}, 0);
      @(negedge clk); reset = 1;
      repeat (25) @(negedge clk);
      a_valid = 0;
      check("ab_no_done", a_dn, 0);
      check("ab_idle", a_busy, 0);
      check("ab_partial", a_chain, 14'h3F80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pe_config_loader.md
# pe_config_loader

Sequencer that loads one PE configuration bitstream into a serial `config_cell` chain, such as the chain threading a `BlockPE` tile.
- Accepts bitstream words over a valid/ready stream and clears the chain.
- Shifts exactly `CHAIN_LEN` bits in, LSB first, one bit per enabled cycle.
- Optionally circulates the chain once to verify the load.
- Sits between the host configuration port and each tile's `config_in`/`config_out` pins.

## Interface

Parameters:
- `WORD_W`, default 32: width of an input bitstream word.
- `CHAIN_LEN`, default 14: total configuration bits in the target chain; must be ≥1.

Ports:
- `clk`: input, 1 bit. Single clock; the chain's `config_clk` is the same clock.
- `reset`: input, 1 bit. Asynchronous, active-low.
- `start`: input, 1 bit. Single-cycle request to begin a load; sampled only in IDLE.
- `s_data`: input, `WORD_W` bits. Bitstream word, LSB shifted first.
- `s_valid`: input, 1 bit. `s_data` valid.
- `s_ready`: output, 1 bit. Loader accepts the word this cycle.
- `cfg_reset`: output, 1 bit. Drives chain `config_reset`; high for one cycle.
- `cfg_shift`: output, 1 bit. Chain shift enable; the chain shifts on `clk` when high.
- `cfg_data`: output, 1 bit. Drives chain `config_in`.
- `cfg_tail`: input, 1 bit. Chain `config_out`, a registered bit.
- `busy`: output, 1 bit. High in every state other than IDLE.
- `done`: output, 1 bit. One-cycle pulse when a load completes.
- `err`: output, 1 bit. Sticky verify mismatch flag; cleared on accepted `start`.

## Operation

States: IDLE → CLEAR → SHIFT → (VERIFY) → FINISH → IDLE.

- **IDLE**
  - `start`=1 → CLEAR; `err` cleared.
- **CLEAR**
  - `cfg_reset`=1 for exactly one cycle; bit counter ← 0; word buffer emptied.
  - → SHIFT.
- **SHIFT**
  - Word buffer: one `WORD_W` register plus a bit index.
  - `s_ready`=1 when the buffer is empty or the current bit is the last of the buffer (back-to-back refill).
  - When a bit is available: `cfg_shift`=1, `cfg_data`=buffer[idx], bit counter +1.
  - When no bit is available: bubble — `cfg_shift`=0, counter holds.
  - At counter = `CHAIN_LEN`-1 with a bit available: shift the final bit, then go to VERIFY (macro on) or FINISH.
  - Unused upper bits of the last word are discarded; no further words are accepted (`s_ready`=0).
- **VERIFY** (macro only)
  - `CHAIN_LEN` cycles with `cfg_shift`=1 and `cfg_data`=`cfg_tail`, so the chain circulates back to its loaded contents.
  - Cycle k compares `cfg_tail` against stored bit k; any mismatch sets `err`.
- **FINISH**
  - `done`=1 for one cycle → IDLE.
- **Boundary behaviour**
  - `start` while `busy`: ignored.
  - `CHAIN_LEN` not a multiple of `WORD_W`: handled as above.
  - `CHAIN_LEN` < `WORD_W`: exactly one word consumed.

## Timing

- Reset values: `s_ready`=0, `cfg_reset`=0, `cfg_shift`=0, `cfg_data`=0, `busy`=0, `done`=0, `err`=0; state IDLE.
- `reset` asserted mid-load: immediate return to IDLE; the chain is left partially loaded; no `done`.
- All outputs are registered, except:
  - `s_ready`, which is combinational from state and buffer.
  - `cfg_data` in VERIFY, which is combinational from `cfg_tail`.
- Latency with `s_valid` held high:
  - Without verify: `start` at cycle 0 → `cfg_reset` at cycle 1 → first shift at cycle 2 → `done` at cycle 2+`CHAIN_LEN`+1.
  - With verify: add `CHAIN_LEN` cycles.
- Throughput: one bit per cycle with no inter-word bubble when `s_valid` stays high.

## Configuration

- Macro `CFG_READBACK_EN`.
- **Defined:**
  - `CHAIN_LEN`-bit shadow copy of the shifted stream.
  - VERIFY state present.
  - `err` functional.
- **Undefined:**
  - No shadow register and no VERIFY state.
  - `err` tied 0.
  - `done` follows the last shift directly.

## Structure

- Shared package `pe_cfg_pkg`:
  - State enum (IDLE, CLEAR, SHIFT, VERIFY, FINISH).
  - `CFG_CNT_W` = clog2(`CHAIN_LEN`+1) helper.
  - Default `WORD_W`.
- One sub-module: `cfg_word_serializer` — word buffer, bit index and `s_ready` logic, exposing a bit-valid/bit-take interface to the FSM.

## Test plan

- **Basic load:** `CHAIN_LEN`=14, `WORD_W`=32, word 0x0000_2A5B, `s_valid` held → `cfg_reset` one cycle; 14 shifts of bits 0x2A5B LSB first; `done` at cycle 17; one word consumed.
- **Multi-word with stalls:** `CHAIN_LEN`=40, words 0xFFFF_FFFF then 0x0000_00A5, `s_valid` low 3 cycles between them → 3 bubble cycles with `cfg_shift`=0; 40 shifts total; top 24 bits of word 2 discarded.
- **Verify pass (macro on):** behavioural chain model, stream 0x1234 with `CHAIN_LEN`=14 → 14 VERIFY cycles; `err`=0; chain contents equal 0x1234 after `done`.
- **Verify fail (macro on):** flip one chain bit on the verify cycle 5 tail readout → `err`=1 after `done`, held until the next `start`.
- **Abort and ignore:** `reset` low at shift 7 → all outputs 0, IDLE. A `start` pulse during SHIFT → ignored; exactly one `done` per accepted load.
